// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the signed add-shift multiplier datapath.
//   WIDTH      default operand width (A, B, S and each product half)
//   CNT_W      default shift-counter width; must be able to hold WIDTH
//   op_t       operation selected for the current cycle
//   op_select  resolves simultaneous control strobes to one operation
package mult_pkg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_CLRLD = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_SHIFT = 3'd4
  } op_t;

  // Fixed priority: Clr_Ld > Sub > Add > Shift. Losing strobes are dropped
  // entirely, so a dropped Shift does not bump the counter either.
  function automatic op_t op_select(input logic clr_ld,
                                    input logic sub,
                                    input logic add,
                                    input logic shift);
    op_t op;
    op = OP_NONE;
    if (clr_ld)      op = OP_CLRLD;
    else if (sub)    op = OP_SUB;
    else if (add)    op = OP_ADD;
    else if (shift)  op = OP_SHIFT;
    return op;
  endfunction

endpackage

// File: rtl/mult_datapath_if.sv
// mult_datapath_if: control strobes, switch operand and register readback
// between the multiplier control FSM (master) and the datapath (slave).
//   Clr_Ld/Shift/Add/Sub  control strobes from the FSM
//   S                     switch operand (multiplicand, or multiplier on load)
//   Aval/Bval             accumulator / multiplier registers (product halves)
//   X                     sign-extension bit
//   M                     Bval[0], steers add/subtract in the FSM
//   Cnt/Done              shifts since last load / all shifts complete
interface mult_datapath_if
  import mult_pkg::*;
  #(parameter int WIDTH = mult_pkg::WIDTH,
    parameter int CNT_W = mult_pkg::CNT_W);

  logic             Clr_Ld;
  logic             Shift;
  logic             Add;
  logic             Sub;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             M;
  logic [CNT_W-1:0] Cnt;
  logic             Done;

  modport master (
    output Clr_Ld, Shift, Add, Sub, S,
    input  Aval, Bval, X, M, Cnt, Done
  );

  modport slave (
    input  Clr_Ld, Shift, Add, Sub, S,
    output Aval, Bval, X, M, Cnt, Done
  );

endinterface

// File: rtl/mult_datapath_adder9.sv
// adder9: combinational (WIDTH+1)-bit signed add/subtract.
//   a    accumulator operand, sign-extended internally
//   b    switch operand, sign-extended internally
//   sub  0: a + b, 1: a - b (invert b plus carry-in)
//   sum  WIDTH+1-bit result; top bit feeds the X register
module adder9 #(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;
  logic [WIDTH:0] b_mod;

  assign a_ext = {a[WIDTH-1], a};
  assign b_ext = {b[WIDTH-1], b};

  // Two's-complement subtract: invert the operand and inject the carry.
  assign b_mod = sub ? ~b_ext : b_ext;
  assign sum   = a_ext + b_mod + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/mult_datapath.sv
// mult_datapath: register/arithmetic datapath of the signed add-shift
// multiplier. Holds accumulator A, multiplier B, sign bit X and a shift
// counter; executes one FSM-requested operation per rising Clk edge.
//   Clk    system clock
//   Reset  asynchronous, active-low reset
//   bus    slave side of mult_datapath_if (strobes, S, register readback)
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH,
  parameter int CNT_W = mult_pkg::CNT_W
) (
  input  logic           Clk,
  input  logic           Reset,
  mult_datapath_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             x_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   sum;
  logic             do_sub;
  op_t              op;

  assign op     = op_select(bus.Clr_Ld, bus.Sub, bus.Add, bus.Shift);
  assign do_sub = (op == OP_SUB);

  adder9 #(.WIDTH(WIDTH)) u_adder9 (
    .a   (a_q),
    .b   (bus.S),
    .sub (do_sub),
    .sum (sum)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (op)
        OP_CLRLD: begin
          a_q   <= '0;
          x_q   <= 1'b0;
          b_q   <= bus.S;
          cnt_q <= '0;
        end
        OP_ADD, OP_SUB: begin
          x_q <= sum[WIDTH];
          a_q <= sum[WIDTH-1:0];
        end
        OP_SHIFT: begin
          // Arithmetic right shift of {X,A,B}: X replicates into A's MSB.
          a_q <= {x_q, a_q[WIDTH-1:1]};
          b_q <= {a_q[0], b_q[WIDTH-1:1]};
          // Data keeps shifting past the last iteration; only the count saturates.
          if (cnt_q != CNT_FULL) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.X    = x_q;
  assign bus.M    = b_q[0];
  assign bus.Cnt  = cnt_q;
  assign bus.Done = (cnt_q == CNT_FULL);

endmodule

// File: tb/tb_mult_datapath.sv
module tb_mult_datapath;
  import mult_pkg::*;

  logic Clk;
  logic Reset;

  mult_datapath_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  mult_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       x;
    int         cnt;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference state: the multiplier registers as plain values.
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic       m_x;
  int         m_cnt;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 8'h00; m_b = 8'h00; m_x = 1'b0; m_cnt = 0;
  endtask

  task automatic model_step(input logic cl, input logic sb, input logic ad,
                            input logic sh, input logic [7:0] s);
    int r;
    logic [8:0] t;
    logic [16:0] v;
    if (cl) begin
      m_a = 8'h00; m_x = 1'b0; m_b = s; m_cnt = 0;
    end else if (sb || ad) begin
      if (sb) r = int'($signed(m_a)) - int'($signed(s));
      else    r = int'($signed(m_a)) + int'($signed(s));
      t = r[8:0];
      m_x = t[8];
      m_a = t[7:0];
    end else if (sh) begin
      v = {m_x, m_a, m_b};
      v = $signed(v) >>> 1;
      m_x = v[16];
      m_a = v[15:8];
      m_b = v[7:0];
      m_cnt = (m_cnt < 8) ? m_cnt + 1 : 8;
    end
  endtask

  task automatic drive(input logic cl, input logic sb, input logic ad,
                       input logic sh, input logic [7:0] s);
    exp_t e;
    @(negedge Clk);
    bus.Clr_Ld = cl;
    bus.Sub    = sb;
    bus.Add    = ad;
    bus.Shift  = sh;
    bus.S      = s;
    model_step(cl, sb, ad, sh, s);
    e.a = m_a; e.b = m_b; e.x = m_x; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge Clk);
      n++;
    end
    #2;
    chk("drain", exp_q.size(), 0);
  endtask

  // Plays the control FSM: add (or subtract on the last pass) when M=1, then shift.
  task automatic multiply(input logic [7:0] a_s, input logic [7:0] b_s);
    drive(1'b1, 1'b0, 1'b0, 1'b0, b_s);
    for (int i = 0; i < 8; i++) begin
      if (m_b[0]) begin
        if (i == 7) drive(1'b0, 1'b1, 1'b0, 1'b0, a_s);
        else        drive(1'b0, 1'b0, 1'b1, 1'b0, a_s);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, a_s);
    end
    idle();
    wait_drain();
  endtask

  // Monitor: every edge with an issued operation is checked one cycle later.
  always @(posedge Clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("aval", int'(bus.Aval), int'(e.a));
      chk("bval", int'(bus.Bval), int'(e.b));
      chk("x",    int'(bus.X),    int'(e.x));
      chk("m",    int'(bus.M),    int'(e.b[0]));
      chk("cnt",  int'(bus.Cnt),  e.cnt);
      chk("done", int'(bus.Done), (e.cnt == 8) ? 1 : 0);
    end
  end

  task automatic check_regs(input string nm, input int a, input int b,
                            input int x, input int cnt);
    chk({nm, "_aval"}, int'(bus.Aval), a);
    chk({nm, "_bval"}, int'(bus.Bval), b);
    chk({nm, "_x"},    int'(bus.X),    x);
    chk({nm, "_cnt"},  int'(bus.Cnt),  cnt);
    chk({nm, "_done"}, int'(bus.Done), (cnt == 8) ? 1 : 0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic [15:0] prod;
    int p;

    Reset = 1'b0;
    bus.Clr_Ld = 1'b0; bus.Sub = 1'b0; bus.Add = 1'b0; bus.Shift = 1'b0;
    bus.S = 8'h00;
    model_reset();
    #12;
    check_regs("por", 0, 0, 0, 0);
    chk("por_m", int'(bus.M), 0);
    @(negedge Clk);
    Reset = 1'b1;

    // Load, then add a negative multiplicand and shift once.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hC5);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hC5);
    idle();
    wait_drain();
    check_regs("add_shift", 'hE2, 'h83, 1, 1);

    // Full 7 * -59 multiply.
    multiply(8'hC5, 8'h07);
    check_regs("mul", 'hFE, 'h63, 1, 8);

    // Shift past saturation: data moves, count holds.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    idle();
    wait_drain();
    check_regs("sat", 'hFF, 'h31, 1, 8);

    // Boundary arithmetic.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h80);
    idle();
    wait_drain();
    check_regs("sub_m128", 'h80, 'h00, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h7F);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h7F);
    idle();
    wait_drain();
    check_regs("add_7f", 'hFE, 'h00, 0, 0);

    // Simultaneous strobes.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h5A);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h11);
    idle();
    wait_drain();
    check_regs("add_shift_same", 'h11, 'h5A, 0, 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h33);
    idle();
    wait_drain();
    check_regs("clr_sub_same", 0, 'h33, 0, 0);

    // Asynchronous reset mid-multiply, away from any clock edge.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h9E);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    idle();
    wait_drain();
    chk("pre_rst_cnt", int'(bus.Cnt), 5);
    Reset = 1'b0;
    model_reset();
    #1;
    check_regs("async_rst", 0, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b1;

    // Random full multiplies checked against the plain signed product.
    for (int k = 0; k < 20; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (k == 0) begin ra = 8'h80; rb = 8'h80; end
      if (k == 1) begin ra = 8'h7F; rb = 8'h80; end
      multiply(ra, rb);
      p = int'($signed(ra)) * int'($signed(rb));
      prod = p[15:0];
      chk("product", int'({bus.Aval, bus.Bval}), int'(prod));
    end

    // Random strobe soup.
    for (int k = 0; k < 300; k++) begin
      drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 0),
            8'($urandom_range(0, 255)));
    end
    idle();
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Register/arithmetic datapath for the 8-bit signed add-shift multiplier.
- Sits directly downstream of the multiplier control FSM and consumes its Clr_Ld, Shift, Add and Sub strobes.
- Holds accumulator A, multiplier B and sign-extension bit X, and performs a 9-bit signed add/subtract of the switch operand S.
- Tracks completed shifts so the FSM and display logic can read progress and completion.

Parameters:
- WIDTH, 8, operand width; A, B, S and the product halves are WIDTH bits, and the adder is WIDTH+1 bits.
- CNT_W, 4, shift-counter width; must hold the value WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Clr_Ld  input  1  clear A/X/count and load B from S.
- Shift  input  1  arithmetic right shift of {X,A,B}.
- Add  input  1  {X,A} <= A + S, signed.
- Sub  input  1  {X,A} <= A - S, signed.
- S  input  WIDTH  switch operand: multiplicand, or multiplier on load.
- Aval  output  WIDTH  accumulator; upper product half.
- Bval  output  WIDTH  multiplier register; lower product half.
- X  output  1  sign-extension bit.
- M  output  1  Bval[0]; tells the FSM whether to add/subtract.
- Cnt  output  CNT_W  number of shifts since the last Clr_Ld.
- Done  output  1  high when Cnt == WIDTH.

Behaviour:
- Reset low, asynchronous: Aval=0, Bval=0, X=0, Cnt=0. Done=0 and M=0 follow from those registers.
- Reset released: operation resumes on the next rising Clk edge. Reset asserted mid-multiply aborts it with no partial result retained.
- One operation per cycle, applied at the rising edge; results are visible one cycle after the strobe.
- Priority: Clr_Ld > Sub > Add > Shift. Lower-priority strobes in the same cycle are ignored entirely, including the Cnt increment.
- Clr_Ld: A<=0, X<=0, B<=S, Cnt<=0.
- Add: sum = {A[W-1],A} + {S[W-1],S}, 9 bits. X<=sum[W], A<=sum[W-1:0]. B and Cnt unchanged.
- Sub: diff = {A[W-1],A} + ~{S[W-1],S} + 1, 9 bits, assigned the same way as Add. B and Cnt unchanged.
- 9-bit arithmetic never overflows for 8-bit operands. Example: 0 - (-128) gives X=0, A=0x80.
- Shift: X unchanged; A<={X,A[W-1:1]}; B<={A[0],B[W-1:1]}; Cnt<=Cnt+1, saturating at WIDTH.
- Shift with Cnt already at WIDTH still shifts the data; Cnt holds and Done stays 1.
- No strobe asserted: all registers hold.
- M=B[0] and Done=(Cnt==WIDTH) are combinational from registers, with no added latency.
- The datapath never decides add versus subtract itself; the FSM asserts Sub on the final iteration when M=1.

Decomposition:
- Package mult_pkg holds: WIDTH and CNT_W defaults; an enumerated op type (OP_NONE, OP_CLRLD, OP_ADD, OP_SUB, OP_SHIFT); a function implementing the strobe priority encode.
- Sub-module adder9: combinational 9-bit add/sub with a sub-select input (invert plus carry-in). Instantiated once.
- Registers and counter stay in mult_datapath.

Test Plan:
- Drive Reset low while A=0x3C, B=0x11, X=1, Cnt=5 with no Clk edge -> Aval=0, Bval=0, X=0, Cnt=0, Done=0 immediately.
- Clr_Ld with S=0x07 -> next cycle Bval=0x07, Aval=0x00, X=0, Cnt=0, M=1.
- From that state, S=0xC5 (-59), Add -> Aval=0xC5, X=1. Then Shift -> Aval=0xE2, Bval=0x83, X=1, Cnt=1.
- Full multiply: load B=0x07, S=0xC5, bench plays the FSM for 8 iterations (add if M, Sub on the 8th if M, then Shift) -> Aval=0xFE, Bval=0x63 (-413), Done=1, Cnt=8.
- A=0x00, S=0x80, Sub -> X=0, Aval=0x80. Then A=0x7F, S=0x7F, Add -> X=0, Aval=0xFE.
- Simultaneous strobes:
  - Add+Shift -> add only, Cnt unchanged.
  - Clr_Ld+Sub -> load only.
  - Shift with Cnt=8 -> data shifts, Cnt stays 8.
